// File: rtl/bus_memory_responder.sv
// bus_memory_responder
//   Single-port word memory behind a strobe/acknowledge bus slave.
//   Each request is latched in IDLE and held in WAIT for WAIT_STATES extra
//   cycles. The access is then performed, and a registered one-cycle ack_o
//   pulse (in-range) or err_o pulse (out-of-range) follows. Dropping the
//   strobe during WAIT abandons the request without side effects.
//
// Parameters
//   DEPTH_WORDS  number of 32-bit words in the backing store (power of two)
//   WAIT_STATES  extra cycles inserted before each access (0..15)
//
// Ports
//   clk     rising-edge clock
//   reset   synchronous, active-high reset (memory contents are kept)
//   stb_i   request strobe, held by the initiator until ack_o/err_o
//   we_i    1 = write, 0 = read
//   adr_i   byte address; bits [1:0] are ignored
//   dat_i   write data
//   sel_i   byte-lane write enables
//   dat_o   registered read data, held until the next in-range read
//   ack_o   one-cycle successful completion pulse
//   err_o   one-cycle out-of-range completion pulse
//   busy_o  high whenever the responder is not idle
module bus_memory_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [31:0] adr_i,
  input  logic [31:0] dat_i,
  input  logic [3:0]  sel_i,
  output logic [31:0] dat_o,
  output logic        ack_o,
  output logic        err_o,
  output logic        busy_o
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        capture;
  logic        access;
  logic        ack_d, err_d;
  logic        ack_q, err_q;
  logic        hit_q;
  logic [31:0] datOut_q;

  logic [29:0] wordAdr_q;
  logic        we_q;
  logic [31:0] dat_q;
  logic [3:0]  sel_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic          inRange;
  logic [AW-1:0] wordIdx;
  logic          unused_adr;

  // Byte offset bits are never used; alignment is the initiator's job.
  assign unused_adr = ^adr_i[1:0];

  // The whole upper address must fall inside the store, so an address just
  // past the end is flagged instead of aliasing onto a low word.
  assign inRange = (wordAdr_q < 30'(DEPTH_WORDS));
  assign wordIdx = wordAdr_q[AW-1:0];

  // Next-state logic. Capture and access are suppressed while reset is
  // asserted, so a reset landing on the access edge never writes memory.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    access  = 1'b0;
    case (state_q)
      IDLE: begin
        if (stb_i) begin
          capture = 1'b1;
          cnt_d   = 4'(WAIT_STATES);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (!stb_i) begin
          cnt_d   = 4'd0;
          state_d = IDLE;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          access  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (reset) begin
      capture = 1'b0;
      access  = 1'b0;
    end
  end

  // The completion pulse is registered on the RESP->IDLE edge. This places
  // it one cycle after RESP, so pulses can never touch back to back.
  always_comb begin
    ack_d = (state_q == RESP) && hit_q;
    err_d = (state_q == RESP) && !hit_q;
  end

  // Control state and the registered completion flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      if (access) begin
        hit_q <= inRange;
      end
    end
  end

  // Request latch. The bus may change freely once the request is accepted.
  always_ff @(posedge clk) begin
    if (capture) begin
      wordAdr_q <= adr_i[31:2];
      we_q      <= we_i;
      dat_q     <= dat_i;
      sel_q     <= sel_i;
    end
  end

  // Read data register: only an in-range read updates it.
  always_ff @(posedge clk) begin
    if (reset) begin
      datOut_q <= 32'd0;
    end else if (access && inRange && !we_q) begin
      datOut_q <= mem[wordIdx];
    end
  end

  // Backing store with per-lane write enables; never cleared by reset.
  always_ff @(posedge clk) begin
    if (access && inRange && we_q) begin
      for (int k = 0; k < 4; k++) begin
        if (sel_q[k]) begin
          mem[wordIdx][8*k +: 8] <= dat_q[8*k +: 8];
        end
      end
    end
  end

  assign dat_o  = datOut_q;
  assign ack_o  = ack_q;
  assign err_o  = err_q;
  assign busy_o = (state_q != IDLE);

endmodule
